// File: rtl/branch_predictor.sv
// Front-end BTB branch predictor with 2-bit saturating counters.
// Combinational IF1 lookup, synchronous EX update and ID invalidate.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if1_pc,
  output logic        bp_taken,
  output logic [31:0] bp_target,
  input  logic        ex_upd_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc_branch,
  input  logic        id_inval,
  input  logic [31:0] id_pc,
  output logic [31:0] mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TLO = IDX_W + 2;
  localparam int THI = IDX_W + TAG_W + 1;

  logic [DEPTH-1:0] valid_q;
  logic [1:0]       ctr_q    [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [31:0]      mis_q;

  logic [IDX_W-1:0] if_idx, ex_idx, id_idx;
  logic [TAG_W-1:0] if_tag, ex_tag, id_tag;

  assign if_idx = if1_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign if_tag = if1_pc[THI:TLO];
  assign ex_tag = ex_pc[THI:TLO];
  assign id_tag = id_pc[THI:TLO];

  logic unused;
  assign unused = ^{if1_pc[31:THI+1], if1_pc[1:0],
                    ex_pc[31:THI+1], ex_pc[1:0],
                    id_pc[31:THI+1], id_pc[1:0]};

  logic       if_hit;
  logic       ex_hit;
  logic       ex_pred;
  logic       ex_mis;
  logic       id_hit;
  logic       collide;
  logic [1:0] ex_ctr;
  logic [1:0] ctr_inc;
  logic [1:0] ctr_dec;

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bp_taken = if_hit && ctr_q[if_idx][1];
  assign bp_target = bp_taken ? target_q[if_idx] : if1_pc + 32'd4;

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_ctr = ctr_q[ex_idx];
  assign ex_pred = ex_hit && ex_ctr[1];
  assign ex_mis = (ex_pred != ex_branch) ||
                  (ex_pred && (target_q[ex_idx] != ex_pc_branch));
  assign ctr_inc = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
  assign ctr_dec = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;

  assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
  assign collide = id_inval && ex_upd_valid && (id_idx == ex_idx);

  assign mispred_cnt = mis_q;

  // valid bits, counters and mispredict count; invalidate overrides EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      mis_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= 2'b00;
      end
    end else begin
      if (ex_upd_valid) begin
        if (ex_hit) begin
          ctr_q[ex_idx] <= ex_branch ? ctr_inc : ctr_dec;
        end else if (ex_branch) begin
          valid_q[ex_idx] <= 1'b1;
          ctr_q[ex_idx] <= 2'b10;
        end
        if (ex_mis) begin
          mis_q <= mis_q + 32'd1;
        end
      end
      if (id_inval && (id_hit || collide)) begin
        valid_q[id_idx] <= 1'b0;
      end
    end
  end

  // tag and target payload; meaningless while the entry is invalid
  always_ff @(posedge clk) begin
    if (ex_upd_valid && ex_branch) begin
      tag_q[ex_idx] <= ex_tag;
      target_q[ex_idx] <= ex_pc_branch;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor with a table-level reference model.
// Directed walk through the key scenarios, then random traffic.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if1_pc;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        ex_upd_valid;
  logic [31:0] ex_pc;
  logic        ex_branch;
  logic [31:0] ex_pc_branch;
  logic        id_inval;
  logic [31:0] id_pc;
  logic [31:0] mispred_cnt;

  branch_predictor dut (
    .clk(clk),
    .rst(rst),
    .if1_pc(if1_pc),
    .bp_taken(bp_taken),
    .bp_target(bp_target),
    .ex_upd_valid(ex_upd_valid),
    .ex_pc(ex_pc),
    .ex_branch(ex_branch),
    .ex_pc_branch(ex_pc_branch),
    .id_inval(id_inval),
    .id_pc(id_pc),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_valid  [64];
  int unsigned m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  logic [31:0] m_mis;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return (pc >> 8) % 256;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i] = 0;
    end
    m_mis = '0;
  endtask

  task automatic model_update();
    int  ei;
    int  ii;
    bit  col;
    bit  idh;
    bit  eh;
    bit  pt;
    ei = idx_of(ex_pc);
    ii = idx_of(id_pc);
    col = id_inval && ex_upd_valid && (ei == ii);
    idh = m_hit(id_pc);
    if (ex_upd_valid) begin
      eh = m_hit(ex_pc);
      pt = eh && (m_ctr[ei] >= 2);
      if ((pt != ex_branch) ||
          (pt && m_target[ei] != ex_pc_branch))
        m_mis = m_mis + 32'd1;
      if (eh && ex_branch) begin
        m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
        m_target[ei] = ex_pc_branch;
      end else if (eh) begin
        m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
      end else if (ex_branch) begin
        m_valid[ei] = 1'b1;
        m_tag[ei] = tag_of(ex_pc);
        m_target[ei] = ex_pc_branch;
        m_ctr[ei] = 2;
      end
    end
    if (id_inval && (idh || col))
      m_valid[ii] = 1'b0;
  endtask

  task automatic idle();
    ex_upd_valid = 1'b0;
    id_inval = 1'b0;
    ex_branch = 1'b0;
  endtask

  // check outputs mid-cycle against the model, then advance one edge
  task automatic cycle();
    bit          mt;
    int          i;
    logic [31:0] mtg;
    @(negedge clk);
    i = idx_of(if1_pc);
    mt = m_hit(if1_pc) && (m_ctr[i] >= 2);
    mtg = mt ? m_target[i] : if1_pc + 32'd4;
    check("lk_taken", {31'd0, bp_taken}, {31'd0, mt});
    check("lk_target", bp_target, mtg);
    check("mis_cnt", mispred_cnt, m_mis);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_upd(logic [31:0] pc, logic tk, logic [31:0] tg);
    ex_upd_valid = 1'b1;
    ex_pc = pc;
    ex_branch = tk;
    ex_pc_branch = tg;
  endtask

  task automatic look(logic [31:0] pc);
    if1_pc = pc;
    #1;
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p = 32'h1c000000;
    p = p | (32'($urandom_range(0, 15)) << 2);
    p = p | (32'($urandom_range(0, 1)) << 8);
    return p;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    ex_pc = '0;
    ex_pc_branch = '0;
    id_pc = '0;
    if1_pc = 32'h1c000000;
    model_reset();
    #12;
    check("rst_taken", {31'd0, bp_taken}, 32'd0);
    check("rst_target", bp_target, 32'h1c000004);
    check("rst_cnt", mispred_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    cycle();
    look(32'hfffffffc);
    check("wrap_target", bp_target, 32'h00000000);

    ex_upd(32'h1c000010, 1'b1, 32'h1c000100);
    cycle();
    idle();
    look(32'h1c000010);
    check("alloc_taken", {31'd0, bp_taken}, 32'd1);
    check("alloc_target", bp_target, 32'h1c000100);
    check("alloc_cnt", mispred_cnt, 32'd1);
    ex_upd(32'h1c000010, 1'b1, 32'h1c000100);
    cycle();
    cycle();
    idle();
    check("sat_cnt", mispred_cnt, 32'd1);

    ex_upd(32'h1c000010, 1'b0, 32'h1c000100);
    cycle();
    idle();
    look(32'h1c000010);
    check("hyst1_taken", {31'd0, bp_taken}, 32'd1);
    check("hyst1_cnt", mispred_cnt, 32'd2);
    ex_upd(32'h1c000010, 1'b0, 32'h1c000100);
    cycle();
    idle();
    look(32'h1c000010);
    check("hyst2_taken", {31'd0, bp_taken}, 32'd0);
    check("hyst2_cnt", mispred_cnt, 32'd3);

    ex_upd(32'h1c000010, 1'b1, 32'h1c000180);
    cycle();
    idle();
    look(32'h1c000010);
    check("retrain_tgt", bp_target, 32'h1c000180);
    id_inval = 1'b1;
    id_pc = 32'h1c000010;
    cycle();
    idle();
    look(32'h1c000010);
    check("inval_taken", {31'd0, bp_taken}, 32'd0);

    ex_upd(32'h1c004010, 1'b1, 32'h1c000200);
    cycle();
    idle();
    look(32'h1c000010);
    check("alias_old", {31'd0, bp_taken}, 32'd0);
    look(32'h1c004010);
    check("alias_new", {31'd0, bp_taken}, 32'd1);
    check("alias_tgt", bp_target, 32'h1c000200);

    ex_upd(32'h1c000020, 1'b1, 32'h1c000300);
    id_inval = 1'b1;
    id_pc = 32'h1c000020;
    cycle();
    idle();
    look(32'h1c000020);
    check("coll_same", {31'd0, bp_taken}, 32'd0);

    ex_upd(32'h1c000024, 1'b1, 32'h1c000400);
    id_inval = 1'b1;
    id_pc = 32'h1c004010;
    cycle();
    idle();
    look(32'h1c000024);
    check("coll_diff_ex", {31'd0, bp_taken}, 32'd1);
    look(32'h1c004010);
    check("coll_diff_id", {31'd0, bp_taken}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        ex_upd(rpc(), 1'($urandom_range(0, 1)),
               32'h1c001000 + 32'($urandom_range(0, 3)) * 4);
      if ($urandom_range(0, 4) == 0) begin
        id_inval = 1'b1;
        id_pc = rpc();
      end
      if1_pc = ($urandom_range(0, 31) == 0) ? 32'hfffffffc : rpc();
      cycle();
    end
    idle();

    ex_upd(32'h1c000040, 1'b1, 32'h1c000500);
    cycle();
    idle();
    look(32'h1c000040);
    check("pre_rst_taken", {31'd0, bp_taken}, 32'd1);
    check("pre_rst_cnt", {31'd0, mispred_cnt != 0}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_taken", {31'd0, bp_taken}, 32'd0);
    check("arst_target", bp_target, 32'h1c000044);
    check("arst_cnt", mispred_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
